// File: rtl/alu_seq_core.sv
// Multi-cycle unsigned ALU: add/sub complete in one BUSY cycle, mul/div iterate WIDTH cycles.
// Start/done handshake; outputs hold until the next accepted request.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         opcode,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               overflow,
    output logic               div_by_zero,
    output logic               zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_q, b_q, mq;
    logic [1:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] sub_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_qbit;
    logic               last_iter;

    logic               finish;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   mq_nx;
    logic [2*WIDTH-1:0] res_nx;
    logic               ov_nx;
    logic               dz_nx;

    assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff  = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
    // Multiply: acc holds the running high half, mq shifts the multiplier out and product bits in.
    assign mul_sum   = acc + (mq[0] ? {1'b0, a_q} : '0);
    // Divide: acc holds the partial remainder, mq shifts the dividend out and quotient bits in.
    assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_qbit  = (div_shift >= {1'b0, b_q});
    assign last_iter = (cnt == CW'(1));

    always_comb begin
        finish = 1'b0;
        acc_nx = acc;
        mq_nx  = mq;
        res_nx = result;
        ov_nx  = 1'b0;
        dz_nx  = 1'b0;
        case (op_q)
            OP_ADD: begin
                finish = 1'b1;
                res_nx = {{(WIDTH-1){1'b0}}, add_sum};
                ov_nx  = add_sum[WIDTH];
            end
            OP_SUB: begin
                finish = 1'b1;
                res_nx = sub_diff;
                ov_nx  = (a_q < b_q);
            end
            OP_MUL: begin
                acc_nx = {1'b0, mul_sum[WIDTH:1]};
                mq_nx  = {mul_sum[0], mq[WIDTH-1:1]};
                finish = last_iter;
                res_nx = {mul_sum[WIDTH:1], mul_sum[0], mq[WIDTH-1:1]};
                ov_nx  = |mul_sum[WIDTH:1];
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    finish = 1'b1;
                    res_nx = '0;
                    dz_nx  = 1'b1;
                end else begin
                    acc_nx = div_qbit ? div_trial : div_shift;
                    mq_nx  = {mq[WIDTH-2:0], div_qbit};
                    finish = last_iter;
                    res_nx = {acc_nx[WIDTH-1:0], mq[WIDTH-2:0], div_qbit};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)  state_nx = BUSY;
            BUSY:    if (finish) state_nx = HOLD;
            HOLD:    if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            mq          <= '0;
            acc         <= '0;
            cnt         <= '0;
            result      <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            zero        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        op_q        <= opcode;
                        mq          <= (opcode == OP_MUL) ? b : a;
                        acc         <= '0;
                        cnt         <= CW'(WIDTH);
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    if (finish) begin
                        cnt         <= '0;
                        result      <= res_nx;
                        overflow    <= ov_nx;
                        div_by_zero <= dz_nx;
                        zero        <= (res_nx == '0);
                        done        <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: hand-computed results, latencies and handshake behaviour.
module tb_alu_seq_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [1:0]  opcode = '0;
    logic [15:0] result;
    logic        done, overflow, div_by_zero, zero;

    int errors = 0;
    int checks = 0;

    alu_seq_core #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opcode(opcode),
        .result(result), .done(done), .overflow(overflow),
        .div_by_zero(div_by_zero), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request: idle edge, acceptance, wait for done, compare outputs and latency.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_ov, input logic exp_dz, input logic exp_z);
        int lat;
        tick();
        a = av; b = bv; opcode = op; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_ov_clr"}, 32'(overflow), 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(result), 32'(exp_res));
        check({tag, "_ov"}, 32'(overflow), 32'(exp_ov));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    endtask

    initial begin
        int completions, drops, first_done;
        logic prev;

        #3;
        check("rst_res", 32'(result), 32'd0);
        check("rst_flags", {28'd0, done, overflow, div_by_zero, zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 1, 16'h0100, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a multiply.
        tick();
        a = 8'hFF; b = 8'hFF; opcode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("midrst_res", 32'(result), 32'd0);
        check("midrst_flags", {28'd0, done, overflow, div_by_zero, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("add_02_03", 2'b00, 8'h02, 8'h03, 1, 16'h0005, 1'b0, 1'b0, 1'b0);

        do_op("sub_05_07", 2'b01, 8'h05, 8'h07, 1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        do_op("sub_33_33", 2'b01, 8'h33, 8'h33, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op("mul_ff_ff", 2'b10, 8'hFF, 8'hFF, 8, 16'hFE01, 1'b1, 1'b0, 1'b0);
        do_op("mul_0f_10", 2'b10, 8'h0F, 8'h10, 8, 16'h00F0, 1'b0, 1'b0, 1'b0);
        do_op("div_200_7", 2'b11, 8'd200, 8'd7, 8, 16'h041C, 1'b0, 1'b0, 1'b0);
        do_op("div_by_0", 2'b11, 8'h10, 8'h00, 1, 16'h0000, 1'b0, 1'b1, 1'b1);

        repeat (3) tick();
        check("idle_done_held", 32'(done), 32'd1);
        check("idle_dz_held", 32'(div_by_zero), 32'd1);

        // start held high for 100 cycles over a multiply, operands scrambled meanwhile.
        a = 8'h12; b = 8'h34; opcode = 2'b10; start = 1'b1;
        tick();
        check("held_done_clr", 32'(done), 32'd0);
        completions = 0; drops = 0; first_done = -1; prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 1 || i == 50) begin
                a = 8'hFF; b = 8'hFF; opcode = 2'b00;
            end
            if (done && !prev) begin
                completions++;
                if (first_done < 0) first_done = i;
            end
            if (prev && !done) drops++;
            prev = done;
        end
        check("held_completions", 32'(completions), 32'd1);
        check("held_first_done", 32'(first_done), 32'd7);
        check("held_drops", 32'(drops), 32'd0);
        check("held_res", 32'(result), 32'h03A8);
        check("held_ov", 32'(overflow), 32'd1);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("held_next_done_clr", 32'(done), 32'd0);
        start = 1'b0;
        tick();
        check("held_next_done", 32'(done), 32'd1);
        check("held_next_res", 32'(result), 32'h01FE);

        // Toggle start and opcode while a divide is in progress.
        tick();
        a = 8'd200; b = 8'd7; opcode = 2'b11; start = 1'b1;
        tick();
        check("tog_done_clr", 32'(done), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            start = (i < 6) ? 1'((i % 2)) : 1'b0;
            opcode = 2'(i);
            a = 8'(i * 13);
            tick();
            if (i == 7) check("tog_not_done_7", 32'(done), 32'd0);
            if (i == 8) check("tog_done_8", 32'(done), 32'd1);
        end
        check("tog_res", 32'(result), 32'h041C);
        check("tog_ov", 32'(overflow), 32'd0);
        do_op("add_80_80", 2'b00, 8'h80, 8'h80, 1, 16'h0100, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
